// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard receiver: conditions the raw lines, deframes bytes, decodes prefixes and emits ps2_key events.
// Optional typematic repeat suppression when PS2_REPEAT_FILTER_EN is defined.
module ps2_key_encoder #(
  parameter int FILT    = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk_i,
  input  logic        ps2_dat_i,
  output logic [10:0] ps2_key,
  output logic        err
);

  localparam int FW = $clog2(FILT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_f, dat_f, clk_f_d;
  logic [FW-1:0] clk_fcnt, dat_fcnt;
  logic          fall;

  state_t        state, state_next;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          timeout_hit;
  logic          byte_stb;

  logic          ext, rel;
  logic [2:0]    skip_cnt;
  logic          is_ack;
  logic [8:0]    event_code;
  logic          suppress;
`ifdef PS2_REPEAT_FILTER_EN
  logic          held;
  logic [8:0]    held_code;
`endif

  // A filtered line only follows its synchronized input after FILT consecutive differing samples.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_f    <= 1'b1;
      dat_f    <= 1'b1;
      clk_f_d  <= 1'b1;
      clk_fcnt <= '0;
      dat_fcnt <= '0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_i};
      dat_sync <= {dat_sync[0], ps2_dat_i};
      clk_f_d  <= clk_f;
      if (clk_sync[1] == clk_f) begin
        clk_fcnt <= '0;
      end else if (clk_fcnt == FW'(FILT - 1)) begin
        clk_f    <= clk_sync[1];
        clk_fcnt <= '0;
      end else begin
        clk_fcnt <= clk_fcnt + 1'b1;
      end
      if (dat_sync[1] == dat_f) begin
        dat_fcnt <= '0;
      end else if (dat_fcnt == FW'(FILT - 1)) begin
        dat_f    <= dat_sync[1];
        dat_fcnt <= '0;
      end else begin
        dat_fcnt <= dat_fcnt + 1'b1;
      end
    end
  end

  assign fall = clk_f_d & ~clk_f;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // A bit edge in the same cycle as the timeout expiry takes priority.
  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE:   if (fall && !dat_f) state_next = DATA;
      DATA:   if (fall && bit_cnt == 3'd7) state_next = PARITY;
      PARITY: if (fall) state_next = STOP;
      STOP:   if (fall) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (state != IDLE && !fall && to_cnt == TW'(TIMEOUT - 1)) begin
      state_next  = IDLE;
      timeout_hit = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      to_cnt    <= '0;
      byte_stb  <= 1'b0;
      err       <= 1'b0;
    end else begin
      byte_stb <= 1'b0;
      err      <= timeout_hit;
      if (state == IDLE || fall) to_cnt <= '0;
      else                       to_cnt <= to_cnt + 1'b1;
      if (fall) begin
        case (state)
          IDLE: bit_cnt <= '0;
          DATA: begin
            shift_reg <= {dat_f, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
          end
          PARITY: par_bit <= dat_f;
          STOP: begin
            if ((^{shift_reg, par_bit}) && dat_f) byte_stb <= 1'b1;
            else                                  err      <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Keyboard housekeeping bytes are dropped only when no prefix is pending.
  always_comb begin
    is_ack = 1'b0;
    case (shift_reg)
      8'hFA, 8'hFE, 8'hEE, 8'hAA, 8'h00, 8'hFF: is_ack = 1'b1;
      default: is_ack = 1'b0;
    endcase
  end

  assign event_code = {ext, shift_reg};
`ifdef PS2_REPEAT_FILTER_EN
  assign suppress = ~rel & held & (held_code == event_code);
`else
  assign suppress = 1'b0;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ps2_key   <= '0;
      ext       <= 1'b0;
      rel       <= 1'b0;
      skip_cnt  <= '0;
`ifdef PS2_REPEAT_FILTER_EN
      held      <= 1'b0;
      held_code <= '0;
`endif
    end else if (timeout_hit) begin
      ext <= 1'b0;
      rel <= 1'b0;
    end else if (byte_stb) begin
      if (skip_cnt != 3'd0) begin
        skip_cnt <= skip_cnt - 3'd1;
      end else if (shift_reg == 8'hE0) begin
        ext <= 1'b1;
      end else if (shift_reg == 8'hF0) begin
        rel <= 1'b1;
      end else if (shift_reg == 8'hE1) begin
        skip_cnt <= 3'd7;
      end else if (!(is_ack && !ext && !rel)) begin
        if (!suppress) ps2_key <= {~ps2_key[10], ~rel, event_code};
        ext <= 1'b0;
        rel <= 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
        if (!rel) begin
          held      <= 1'b1;
          held_code <= event_code;
        end else if (held_code == event_code) begin
          held <= 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Directed self-checking bench for ps2_key_encoder: bit-bangs PS/2 frames and checks event words, toggles and err pulses.
module tb_ps2_key_encoder;

  localparam int TMO = 1000;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [10:0] ps2_key;
  logic        err;

  int tests = 0;
  int fails = 0;
  int toggles = 0;
  int err_cycles = 0;
  int err_pulses = 0;
  logic last_tog = 1'b0;
  logic last_err = 1'b0;

  ps2_key_encoder #(.FILT(8), .TIMEOUT(TMO)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_clk_i (ps2_clk),
    .ps2_dat_i (ps2_dat),
    .ps2_key   (ps2_key),
    .err       (err)
  );

  always #5 clk_sys = ~clk_sys;

  // Event and error activity is tallied on the falling clock edge.
  always @(negedge clk_sys) begin
    if (ps2_key[10] !== last_tog) toggles <= toggles + 1;
    last_tog <= ps2_key[10];
    if (err === 1'b1) err_cycles <= err_cycles + 1;
    if (err === 1'b1 && last_err !== 1'b1) err_pulses <= err_pulses + 1;
    last_err <= err;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    repeat (15) @(posedge clk_sys);
    ps2_clk = 1'b0;
    repeat (20) @(posedge clk_sys);
    ps2_clk = 1'b1;
    repeat (5) @(posedge clk_sys);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(1'b1);
    ps2_dat = 1'b1;
    repeat (30) @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset;
    repeat (5) @(posedge clk_sys);
    #1;
    tests++;
    if (ps2_key !== 11'h000) begin
      fails++; $display("[TB] FAIL reset_key: got %h expected 000", ps2_key);
    end
    tests++;
    if (err !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_err: got %b expected 0", err);
    end
    reset_n = 1'b1;
    repeat (20) @(posedge clk_sys);
  endtask

  task automatic test_make;
    int t0, e0;
    t0 = toggles; e0 = err_pulses;
    send_byte(8'h29, 1'b0);
    tests++;
    if (ps2_key[9:0] !== 10'h229) begin
      fails++; $display("[TB] FAIL make_code: got %h expected 229", ps2_key[9:0]);
    end
    tests++;
    if (toggles - t0 !== 1) begin
      fails++; $display("[TB] FAIL make_toggle: got %0d expected 1", toggles - t0);
    end
    tests++;
    if (err_pulses !== e0) begin
      fails++; $display("[TB] FAIL make_err: got %0d expected %0d", err_pulses, e0);
    end
  endtask

  task automatic test_release;
    int t0;
    t0 = toggles;
    send_byte(8'hF0, 1'b0);
    send_byte(8'h29, 1'b0);
    tests++;
    if (ps2_key[9:0] !== 10'h029) begin
      fails++; $display("[TB] FAIL release_code: got %h expected 029", ps2_key[9:0]);
    end
    tests++;
    if (toggles - t0 !== 1) begin
      fails++; $display("[TB] FAIL release_toggle: got %0d expected 1", toggles - t0);
    end
  endtask

  task automatic test_extended;
    int t0;
    t0 = toggles;
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    tests++;
    if (ps2_key[9:0] !== 10'h375) begin
      fails++; $display("[TB] FAIL ext_make: got %h expected 375", ps2_key[9:0]);
    end
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    tests++;
    if (ps2_key[9:0] !== 10'h175) begin
      fails++; $display("[TB] FAIL ext_release: got %h expected 175", ps2_key[9:0]);
    end
    tests++;
    if (toggles - t0 !== 2) begin
      fails++; $display("[TB] FAIL ext_toggles: got %0d expected 2", toggles - t0);
    end
  endtask

  task automatic test_parity_error;
    int t0, e0, c0;
    t0 = toggles; e0 = err_pulses; c0 = err_cycles;
    send_byte(8'h29, 1'b1);
    tests++;
    if (err_pulses - e0 !== 1) begin
      fails++; $display("[TB] FAIL parity_err_pulse: got %0d expected 1", err_pulses - e0);
    end
    tests++;
    if (err_cycles - c0 !== 1) begin
      fails++; $display("[TB] FAIL parity_err_width: got %0d expected 1", err_cycles - c0);
    end
    tests++;
    if (toggles - t0 !== 0) begin
      fails++; $display("[TB] FAIL parity_no_toggle: got %0d expected 0", toggles - t0);
    end
    send_byte(8'h1C, 1'b0);
    tests++;
    if (ps2_key[9:0] !== 10'h21C) begin
      fails++; $display("[TB] FAIL parity_recover: got %h expected 21C", ps2_key[9:0]);
    end
  endtask

  task automatic test_ack_discard;
    int t0;
    t0 = toggles;
    send_byte(8'hFA, 1'b0);
    tests++;
    if (toggles - t0 !== 0 || ps2_key[9:0] !== 10'h21C) begin
      fails++; $display("[TB] FAIL ack_discard: got toggles %0d key %h expected 0 and 21C", toggles - t0, ps2_key[9:0]);
    end
  endtask

  task automatic test_timeout;
    int e0, c0, t0;
    send_byte(8'hE0, 1'b0);
    e0 = err_pulses; c0 = err_cycles; t0 = toggles;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_dat = 1'b1;
    repeat (TMO + 10) @(posedge clk_sys);
    #1;
    tests++;
    if (err_pulses - e0 !== 1 || err_cycles - c0 !== 1) begin
      fails++; $display("[TB] FAIL timeout_err: got pulses %0d cycles %0d expected 1 and 1", err_pulses - e0, err_cycles - c0);
    end
    send_byte(8'h16, 1'b0);
    tests++;
    if (ps2_key[9:0] !== 10'h216) begin
      fails++; $display("[TB] FAIL timeout_recover: got %h expected 216", ps2_key[9:0]);
    end
    tests++;
    if (toggles - t0 !== 1) begin
      fails++; $display("[TB] FAIL timeout_toggle: got %0d expected 1", toggles - t0);
    end
  endtask

  task automatic test_pause_skip;
    logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    int t0;
    t0 = toggles;
    for (int i = 0; i < 8; i++) send_byte(seq[i], 1'b0);
    tests++;
    if (toggles - t0 !== 0) begin
      fails++; $display("[TB] FAIL pause_silent: got %0d expected 0", toggles - t0);
    end
    send_byte(8'h5A, 1'b0);
    tests++;
    if (ps2_key[9:0] !== 10'h25A) begin
      fails++; $display("[TB] FAIL pause_after: got %h expected 25A", ps2_key[9:0]);
    end
  endtask

  task automatic test_repeat;
    int t0, exp_t;
`ifdef PS2_REPEAT_FILTER_EN
    exp_t = 2;
`else
    exp_t = 4;
`endif
    t0 = toggles;
    send_byte(8'h29, 1'b0);
    send_byte(8'h29, 1'b0);
    send_byte(8'h29, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h29, 1'b0);
    tests++;
    if (toggles - t0 !== exp_t) begin
      fails++; $display("[TB] FAIL repeat_toggles: got %0d expected %0d", toggles - t0, exp_t);
    end
    tests++;
    if (ps2_key[9:0] !== 10'h029) begin
      fails++; $display("[TB] FAIL repeat_final: got %h expected 029", ps2_key[9:0]);
    end
  endtask

  task automatic test_reset_mid_frame;
    int e0, t0;
    e0 = err_pulses;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_dat = 1'b1;
    ps2_clk = 1'b1;
    reset_n = 1'b0;
    repeat (5) @(posedge clk_sys);
    #1;
    tests++;
    if (ps2_key !== 11'h000) begin
      fails++; $display("[TB] FAIL midreset_key: got %h expected 000", ps2_key);
    end
    reset_n = 1'b1;
    repeat (30) @(posedge clk_sys);
    #1;
    tests++;
    if (err_pulses !== e0) begin
      fails++; $display("[TB] FAIL midreset_err: got %0d expected %0d", err_pulses, e0);
    end
    t0 = toggles;
    send_byte(8'h29, 1'b0);
    tests++;
    if (ps2_key !== 11'h629 || toggles - t0 !== 1) begin
      fails++; $display("[TB] FAIL midreset_recover: got %h toggles %0d expected 629 and 1", ps2_key, toggles - t0);
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_release();
    test_extended();
    test_parity_error();
    test_ack_discard();
    test_timeout();
    test_pause_skip();
    test_repeat();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
